// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - shared state encoding and parameter defaults for seq_gen
package seq_gen_pkg;

   localparam int DEFAULT_WIDTH      = 8;
   localparam int DEFAULT_RUN_TARGET = 4;
   localparam int REPS_W             = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_run_tracker.sv
// rtl/seq_run_tracker.sv - counts consecutive equal consumed bits, flags a run of RUN_TARGET
module seq_run_tracker #(
   parameter int RUN_TARGET = 4
) (
   input  logic Clock,
   input  logic Reset,
   input  logic consume,
   input  logic bit_in,
   input  logic clear,
   output logic z
);

   localparam int RW = $clog2(RUN_TARGET + 1);

   logic [RW-1:0] run;
   logic [RW-1:0] run_nxt;
   logic          prev_bit;

   // run==0 means no bit consumed since clear, so the first bit always starts a run of 1
   always_comb begin
      run_nxt = RW'(1);
      if (run != '0 && bit_in == prev_bit) begin
         if (run == RW'(RUN_TARGET))
            run_nxt = run;
         else
            run_nxt = run + 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         run      <= '0;
         prev_bit <= 1'b0;
         z        <= 1'b0;
      end else if (clear) begin
         run      <= '0;
         prev_bit <= 1'b0;
         z        <= 1'b0;
      end else if (consume) begin
         prev_bit <= bit_in;
         run      <= run_nxt;
         z        <= (run_nxt == RW'(RUN_TARGET));
      end
   end

endmodule

// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - serial pattern generator with repeat passes, step gating and run detection
module seq_gen
   import seq_gen_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int RUN_TARGET = DEFAULT_RUN_TARGET
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [WIDTH-1:0]        pattern,
   input  logic [$clog2(WIDTH):0]  length,
   input  logic [REPS_W-1:0]       reps,
   input  logic                    step,
   input  logic                    abort,
   output logic                    w_out,
   output logic                    w_valid,
   output logic                    z_expect,
   output logic                    done,
   output logic [1:0]              state
);

   localparam int IW = $clog2(WIDTH);
   localparam int LW = IW + 1;

   state_t            state_q;
   logic [WIDTH-1:0]  pat_r;
   logic [IW-1:0]     len_m1_r;
   logic [REPS_W-1:0] reps_r;
   logic [IW-1:0]     idx;
   logic [REPS_W-1:0] pass_cnt;
   logic [IW-1:0]     eff_m1;
   logic              accept;
   logic              consume;

   // zero or oversize lengths fall back to the full pattern width
   always_comb begin
      eff_m1 = IW'(WIDTH - 1);
      if (length != '0 && length <= LW'(WIDTH))
         eff_m1 = IW'(length - 1'b1);
   end

   assign accept  = (state_q == ST_IDLE) && load_valid;
   assign consume = (state_q == ST_SHIFT) && step && !abort;
   assign state   = state_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         load_ready <= 1'b1;
         w_valid    <= 1'b0;
         w_out      <= 1'b0;
         done       <= 1'b0;
         pat_r      <= '0;
         len_m1_r   <= '0;
         reps_r     <= '0;
         idx        <= '0;
         pass_cnt   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done <= 1'b0;
               if (load_valid) begin
                  pat_r      <= pattern;
                  len_m1_r   <= eff_m1;
                  reps_r     <= reps;
                  idx        <= eff_m1;
                  pass_cnt   <= '0;
                  w_out      <= pattern[eff_m1];
                  w_valid    <= 1'b1;
                  load_ready <= 1'b0;
                  state_q    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (abort) begin
                  w_valid    <= 1'b0;
                  w_out      <= 1'b0;
                  load_ready <= 1'b1;
                  state_q    <= ST_IDLE;
               end else if (step) begin
                  if (idx != '0) begin
                     idx   <= idx - 1'b1;
                     w_out <= pat_r[idx - 1'b1];
                  end else if (pass_cnt != reps_r) begin
                     // next pass starts immediately, no bubble
                     idx      <= len_m1_r;
                     pass_cnt <= pass_cnt + 1'b1;
                     w_out    <= pat_r[len_m1_r];
                  end else begin
                     w_valid <= 1'b0;
                     w_out   <= 1'b0;
                     done    <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               done       <= 1'b0;
               load_ready <= 1'b1;
               state_q    <= ST_IDLE;
            end
            default: begin
               done       <= 1'b0;
               w_valid    <= 1'b0;
               w_out      <= 1'b0;
               load_ready <= 1'b1;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   seq_run_tracker #(
      .RUN_TARGET (RUN_TARGET)
   ) u_run_tracker (
      .Clock   (Clock),
      .Reset   (Reset),
      .consume (consume),
      .bit_in  (w_out),
      .clear   (accept),
      .z       (z_expect)
   );

endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - scoreboard bench for seq_gen
module tb_seq_gen;

   localparam logic [1:0] I = 2'd0;
   localparam logic [1:0] S = 2'd1;
   localparam logic [1:0] D = 2'd2;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] pattern;
   logic [3:0] length;
   logic [3:0] reps;
   logic       step;
   logic       abort;
   logic       w_out;
   logic       w_valid;
   logic       z_expect;
   logic       done;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;
   logic [6:0] sb[$];

   wire [6:0] obs = {state, load_ready, w_valid, w_out, z_expect, done};

   always #5 Clock = ~Clock;

   seq_gen dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .pattern    (pattern),
      .length     (length),
      .reps       (reps),
      .step       (step),
      .abort      (abort),
      .w_out      (w_out),
      .w_valid    (w_valid),
      .z_expect   (z_expect),
      .done       (done),
      .state      (state)
   );

   function automatic logic [6:0] ex(input logic [1:0] st, input logic lr, input logic wv,
                                     input logic wo, input logic z, input logic d);
      return {st, lr, wv, wo, z, d};
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] e;
      Reset = 1'b1; load_valid = 1'b1; step = 1'b1; abort = 1'b0;
      pattern = 8'hFF; length = 4'd8; reps = 4'd0;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) begin Reset = 1'b0; load_valid = 1'b0; end
         sb.push_back(ex(I, 1, 0, 0, 0, 0));
         tick();
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset c%0d: got %b expected %b", c, obs, e);
         end
      end
   endtask

   task automatic test_basic();
      logic [6:0] e;
      pattern = 8'b0000_1111; length = 4'd8; reps = 4'd0; step = 1'b1;
      for (int c = 0; c < 10; c++) begin
         int c1;
         c1 = c + 1;
         load_valid = (c == 0);
         if (c1 <= 8)       sb.push_back(ex(S, 0, 1, c1 >= 5, c1 == 5, 0));
         else if (c1 == 9)  sb.push_back(ex(D, 0, 0, 0, 1, 1));
         else               sb.push_back(ex(I, 1, 0, 0, 1, 0));
         tick();
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL basic c%0d: got %b expected %b", c1, obs, e);
         end
      end
   endtask

   task automatic test_len1_reps();
      logic [6:0] e;
      pattern = 8'b1010_0101; length = 4'd1; reps = 4'd3; step = 1'b1;
      for (int c = 0; c < 6; c++) begin
         int c1;
         c1 = c + 1;
         load_valid = (c == 0);
         if (c1 <= 4)       sb.push_back(ex(S, 0, 1, 1, 0, 0));
         else if (c1 == 5)  sb.push_back(ex(D, 0, 0, 0, 1, 1));
         else               sb.push_back(ex(I, 1, 0, 0, 1, 0));
         tick();
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL len1_reps c%0d: got %b expected %b", c1, obs, e);
         end
      end
   endtask

   task automatic test_len0_step_toggle();
      logic [6:0] e;
      pattern = 8'hF0; length = 4'd0; reps = 4'd0;
      for (int c = 0; c < 18; c++) begin
         int c1;
         int k;
         c1 = c + 1;
         load_valid = (c == 0);
         step = (c != 0) && (c % 2 == 0);
         if (c1 <= 16) begin
            k = (c1 - 1) / 2;
            sb.push_back(ex(S, 0, 1, pattern[7-k], (c1 == 9) || (c1 == 10), 0));
         end else if (c1 == 17) begin
            sb.push_back(ex(D, 0, 0, 0, 1, 1));
         end else begin
            sb.push_back(ex(I, 1, 0, 0, 1, 0));
         end
         tick();
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL len0_toggle c%0d: got %b expected %b", c1, obs, e);
         end
      end
   endtask

   task automatic test_abort();
      logic [6:0] e;
      pattern = 8'hFF; length = 4'd8; reps = 4'd0; step = 1'b1;
      for (int c = 0; c < 5; c++) begin
         int c1;
         c1 = c + 1;
         load_valid = (c == 0);
         abort = (c == 3) || (c == 4);
         if (c1 <= 3) sb.push_back(ex(S, 0, 1, 1, 0, 0));
         else         sb.push_back(ex(I, 1, 0, 0, 0, 0));
         tick();
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL abort c%0d: got %b expected %b", c1, obs, e);
         end
      end
      abort = 1'b0;
   endtask

   task automatic test_reset_mid_job();
      logic [6:0] e;
      pattern = 8'hFF; length = 4'd8; reps = 4'd0; step = 1'b1;
      for (int c = 0; c < 16; c++) begin
         int c1;
         c1 = c + 1;
         load_valid = (c == 0) || (c == 5) || (c == 6);
         Reset = (c == 5);
         if (c1 <= 5)       sb.push_back(ex(S, 0, 1, 1, c1 == 5, 0));
         else if (c1 == 6)  sb.push_back(ex(I, 1, 0, 0, 0, 0));
         else if (c1 <= 14) sb.push_back(ex(S, 0, 1, 1, c1 >= 11, 0));
         else if (c1 == 15) sb.push_back(ex(D, 0, 0, 0, 1, 1));
         else               sb.push_back(ex(I, 1, 0, 0, 1, 0));
         tick();
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset_mid c%0d: got %b expected %b", c1, obs, e);
         end
      end
      Reset = 1'b0;
   endtask

   task automatic test_held_load();
      logic [6:0] e;
      pattern = 8'h02; length = 4'd2; reps = 4'd0; step = 1'b1;
      for (int c = 0; c < 9; c++) begin
         int c1;
         c1 = c + 1;
         load_valid = (c < 8);
         if (c1 == 9) begin
            sb.push_back(ex(I, 1, 0, 0, 0, 0));
         end else begin
            case ((c1 - 1) % 4)
               0:       sb.push_back(ex(S, 0, 1, 1, 0, 0));
               1:       sb.push_back(ex(S, 0, 1, 0, 0, 0));
               2:       sb.push_back(ex(D, 0, 0, 0, 0, 1));
               default: sb.push_back(ex(I, 1, 0, 0, 0, 0));
            endcase
         end
         tick();
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL held_load c%0d: got %b expected %b", c1, obs, e);
         end
      end
      load_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len1_reps();
      test_len0_step_toggle();
      test_abort();
      test_reset_mid_job();
      test_held_load();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
